// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the FIFO stream reader.
// Buffer depth is fixed at two words; beat count derives from the widths.
package fifo_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OUT_WIDTH  = 8;
    localparam int BUF_DEPTH          = 2;

    function automatic int beats(int dw, int ow);
        return dw / ow;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus narrow valid/ready stream, grouped as one bundle.
// master = the reader; slave = FIFO and sink side.
interface fifo_stream_reader_if
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
) ();

    logic                  fifo_empty_in;
    logic [DATA_WIDTH-1:0] fifo_data_in;
    logic                  fifo_valid_in;
    logic                  fifo_deq_out;
    logic [OUT_WIDTH-1:0]  out_data_out;
    logic                  out_valid_out;
    logic                  out_ready_in;
    logic                  out_last_out;

    modport master (
        input  fifo_empty_in,
        input  fifo_data_in,
        input  fifo_valid_in,
        input  out_ready_in,
        output fifo_deq_out,
        output out_data_out,
        output out_valid_out,
        output out_last_out
    );

    modport slave (
        output fifo_empty_in,
        output fifo_data_in,
        output fifo_valid_in,
        output out_ready_in,
        input  fifo_deq_out,
        input  out_data_out,
        input  out_valid_out,
        input  out_last_out
    );

endinterface

// File: rtl/fifo_stream_reader_word_serializer.sv
// Splits the head word into MSB-first beats and strobes pop on the last one.
module word_serializer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] word_i,
    input  logic                  word_valid_i,
    input  logic                  ready_i,
    output logic [OUT_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  pop_o
);

    localparam int BEATS = beats(DATA_WIDTH, OUT_WIDTH);
    localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IW-1:0] LAST = IW'(BEATS - 1);

    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  at_last;
    logic                  fire;

    // Shift the current beat up to the MSBs so the select stays constant.
    assign shifted = word_i << (int'(idx_q) * OUT_WIDTH);
    assign at_last = (idx_q == LAST);
    assign fire    = word_valid_i && ready_i;

    assign valid_o = word_valid_i;
    assign last_o  = word_valid_i && at_last;
    assign data_o  = word_valid_i ? shifted[DATA_WIDTH-1 -: OUT_WIDTH] : '0;
    assign pop_o   = fire && at_last;

    always_comb begin
        idx_d = idx_q;
        if (fire) begin
            idx_d = at_last ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO read master: credit-limited deq, 2-word buffer, narrow stream out.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEFAULT_OUT_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 enable_in,
    fifo_stream_reader_if.master bus,
    output logic [CNT_WIDTH-1:0] words_sent_out,
    output logic                 err_out
);

    if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_width_chk
        $fatal(1, "DATA_WIDTH must be a multiple of OUT_WIDTH");
    end

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
    logic                  hd_q, hd_d;
    logic [1:0]            occ_q, occ_d;
    logic                  infl_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic       push;
    logic       pop;
    logic       tail;
    logic [1:0] credits;
    logic       deq;

    // Buffered plus in-flight words never exceed the buffer, so no overflow.
    assign credits = occ_q + {1'b0, infl_q};
    assign deq     = rst_n_in && enable_in && !bus.fifo_empty_in
                     && (credits < DEPTH);
    assign push    = bus.fifo_valid_in && infl_q;
    assign tail    = hd_q ^ occ_q[0];

    assign bus.fifo_deq_out = deq;
    assign words_sent_out   = cnt_q;
    assign err_out          = err_q;

    always_comb begin
        occ_d = occ_q + 2'(push) - 2'(pop);
        hd_d  = hd_q ^ pop;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hd_q   <= 1'b0;
            occ_q  <= '0;
            infl_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            hd_q   <= hd_d;
            occ_q  <= occ_d;
            infl_q <= deq;
            if (push) begin
                buf_q[tail] <= bus.fifo_data_in;
            end
            if (bus.fifo_valid_in && !infl_q) begin
                err_q <= 1'b1;
            end
            if (pop) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    word_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_ser (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .word_i       (buf_q[hd_q]),
        .word_valid_i (occ_q != 2'd0),
        .ready_i      (bus.out_ready_in),
        .data_o       (bus.out_data_out),
        .valid_o      (bus.out_valid_out),
        .last_o       (bus.out_last_out),
        .pop_o        (pop)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a 1-cycle-latency FIFO model.
module tb_fifo_stream_reader;

    logic clk;
    logic rst_n;
    logic enable;
    logic [15:0] words_sent;
    logic err;

    fifo_stream_reader_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (32),
        .OUT_WIDTH  (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .enable_in      (enable),
        .bus            (bus),
        .words_sent_out (words_sent),
        .err_out        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic       exp_deq;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_last;
    } vec_t;

    vec_t tbl [11];

    int tests = 0;
    int fails = 0;

    logic [31:0] q [$];
    logic [7:0]  log_d [$];
    logic        log_l [$];

    logic       obs_deq, obs_valid, obs_last;
    logic [7:0] obs_data;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       stable_bad;
    logic       overread;
    int         occ_m;
    int         deq_cnt;
    int         valid_cnt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        logic fire;
        @(negedge clk);
        obs_deq   = bus.fifo_deq_out;
        obs_valid = bus.out_valid_out;
        obs_data  = bus.out_data_out;
        obs_last  = bus.out_last_out;
        if (prev_stall && (!obs_valid || obs_data !== prev_data
                           || obs_last !== prev_last))
            stable_bad = 1'b1;
        prev_stall = obs_valid && !bus.out_ready_in;
        prev_data  = obs_data;
        prev_last  = obs_last;
        fire = obs_valid && bus.out_ready_in;
        if (fire) begin
            log_d.push_back(obs_data);
            log_l.push_back(obs_last);
        end
        if (obs_deq) deq_cnt++;
        if (obs_valid) valid_cnt++;
        if (occ_m + int'(bus.fifo_valid_in) + int'(obs_deq) > 2)
            overread = 1'b1;
        occ_m = occ_m + int'(bus.fifo_valid_in) - int'(fire && obs_last);
        @(posedge clk);
        #1;
        if (obs_deq && q.size() > 0) begin
            bus.fifo_valid_in = 1'b1;
            bus.fifo_data_in  = q.pop_front();
        end else begin
            bus.fifo_valid_in = 1'b0;
            bus.fifo_data_in  = '0;
        end
        bus.fifo_empty_in = (q.size() == 0);
    endtask

    task automatic clear_obs();
        log_d.delete();
        log_l.delete();
        occ_m      = 0;
        prev_stall = 1'b0;
        stable_bad = 1'b0;
        overread   = 1'b0;
        deq_cnt    = 0;
        valid_cnt  = 0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        bus.out_ready_in  = 1'b0;
        bus.fifo_valid_in = 1'b0;
        bus.fifo_data_in  = '0;
        q.delete();
        bus.fifo_empty_in = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        clear_obs();
    endtask

    task automatic check_log(input string name, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2,
                             input int nw);
        logic [31:0] words [3];
        logic [31:0] w;
        int nerr;
        words[0] = w0;
        words[1] = w1;
        words[2] = w2;
        nerr = 0;
        chk({name, " beat count"}, log_d.size(), 4 * nw);
        for (int k = 0; k < log_d.size() && k < 4 * nw; k++) begin
            w = words[k / 4];
            if (log_d[k] !== w[31 - 8 * (k % 4) -: 8]) nerr++;
            if (log_l[k] !== ((k % 4) == 3)) nerr++;
        end
        chk({name, " beat errors"}, nerr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'hA1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'hB2, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'hC3, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'hD4, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

        clear_obs();
        rst_n  = 1'b0;
        enable = 1'b1;
        bus.fifo_empty_in = 1'b0;
        bus.fifo_valid_in = 1'b0;
        bus.fifo_data_in  = '0;
        bus.out_ready_in  = 1'b1;
        #1;
        chk("rst deq", bus.fifo_deq_out, 0);
        chk("rst valid", bus.out_valid_out, 0);
        chk("rst last", bus.out_last_out, 0);
        chk("rst data", bus.out_data_out, 0);
        chk("rst words", words_sent, 0);
        chk("rst err", err, 0);

        // Plain stream, ready held high
        do_reset();
        q.push_back(32'hA1B2C3D4);
        q.push_back(32'h11223344);
        bus.fifo_empty_in = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.out_ready_in = tbl[i].ready;
            cyc();
            chk($sformatf("stream row%0d", i),
                {21'd0, obs_deq, obs_valid, obs_data, obs_last},
                {21'd0, tbl[i].exp_deq, tbl[i].exp_valid,
                 tbl[i].exp_data, tbl[i].exp_last});
        end
        chk("stream words", words_sent, 2);
        chk("stream err", err, 0);

        // Backpressure with ready = 1,0,0 repeating
        do_reset();
        q.push_back(32'h01020304);
        q.push_back(32'h05060708);
        q.push_back(32'h090A0B0C);
        bus.fifo_empty_in = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus.out_ready_in = (i % 3 == 0);
            cyc();
        end
        check_log("bp", 32'h01020304, 32'h05060708, 32'h090A0B0C, 3);
        chk("bp stable", stable_bad, 0);
        chk("bp overread", overread, 0);
        chk("bp words", words_sent, 3);

        // Empty for 10 cycles, then a single word
        do_reset();
        enable = 1'b1;
        bus.out_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("empty deq", deq_cnt, 0);
        chk("empty valid", valid_cnt, 0);
        q.push_back(32'hCAFEF00D);
        bus.fifo_empty_in = 1'b0;
        cyc();
        chk("refill deq", obs_deq, 1);
        for (int i = 0; i < 10; i++) cyc();
        check_log("refill", 32'hCAFEF00D, 32'h0, 32'h0, 1);
        chk("refill words", words_sent, 1);

        // Enable dropped with one word in flight
        do_reset();
        q.push_back(32'h55667788);
        q.push_back(32'h99AABBCC);
        bus.fifo_empty_in = 1'b0;
        bus.out_ready_in  = 1'b1;
        enable = 1'b1;
        cyc();
        chk("en first deq", obs_deq, 1);
        enable  = 1'b0;
        deq_cnt = 0;
        for (int i = 0; i < 10; i++) cyc();
        chk("en no deq", deq_cnt, 0);
        check_log("en", 32'h55667788, 32'h0, 32'h0, 1);
        chk("en fifo left", q.size(), 1);
        chk("en words", words_sent, 1);

        // Reset after the second beat of a word
        do_reset();
        q.push_back(32'hDEADBEEF);
        q.push_back(32'h01020304);
        bus.fifo_empty_in = 1'b0;
        bus.out_ready_in  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 20 && log_d.size() < 2; i++) cyc();
        chk("mid two beats", log_d.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("mid rst valid", bus.out_valid_out, 0);
        chk("mid rst last", bus.out_last_out, 0);
        chk("mid rst data", bus.out_data_out, 0);
        chk("mid rst deq", bus.fifo_deq_out, 0);
        chk("mid rst words", words_sent, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        clear_obs();
        chk("mid post words", words_sent, 0);
        q.push_back(32'h70818293);
        bus.fifo_empty_in = 1'b0;
        for (int i = 0; i < 8; i++) cyc();
        check_log("mid", 32'h70818293, 32'h0, 32'h0, 1);
        chk("mid words", words_sent, 1);
        chk("mid err", err, 0);

        // Spurious read data with nothing in flight
        do_reset();
        bus.out_ready_in  = 1'b1;
        bus.fifo_valid_in = 1'b1;
        bus.fifo_data_in  = 32'hBADBAD00;
        cyc();
        chk("spur err", err, 1);
        for (int i = 0; i < 4; i++) cyc();
        chk("spur sticky", err, 1);
        chk("spur no beat", valid_cnt, 0);
        chk("spur words", words_sent, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
